// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 stage constants and state types
package arc4_pkg;

  localparam int S_DEPTH = 256;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = ADDR_W + 1;
  localparam int ERR_W   = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } readback_state_t;

endpackage

// File: rtl/s_readback_if.sv
// rtl/s_readback_if.sv - start handshake, S-memory port and result bundle for s_readback
interface s_readback_if;
  import arc4_pkg::*;

  logic              en;
  logic              rdy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rddata;
  logic              wren;
  logic              pass;
  logic [ADDR_W-1:0] err_addr;
  logic [ERR_W-1:0]  err_count;
  logic [DATA_W-1:0] checksum;

  modport slave (
    input  en, rddata,
    output rdy, addr, wren, pass, err_addr, err_count, checksum
  );

  modport master (
    output en, rddata,
    input  rdy, addr, wren, pass, err_addr, err_count, checksum
  );

endinterface

// File: rtl/s_readback.sv
// rtl/s_readback.sv - sweeps S memory, checks S[i]==i, reports pass/first error/count/checksum
module s_readback
  import arc4_pkg::*;
#(
  parameter int CHECK_IDENTITY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  s_readback_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_READ  = READ;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_addr;
  logic              pass_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [ERR_W-1:0]  err_count_q;
  logic [DATA_W-1:0] checksum_q;
  logic              mismatch;
  logic [ERR_W-1:0]  err_count_nx;

  assign cnt_inc      = cnt + 1'b1;
  assign mismatch     = (CHECK_IDENTITY != 0) && cap_valid && (bus.rddata != cap_addr);
  assign err_count_nx = err_count_q + ERR_W'(mismatch);

  // Bit 8 of the counter marks the step past address 255, ending the read phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cap_valid   <= 1'b0;
      cap_addr    <= '0;
      pass_q      <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
      checksum_q  <= '0;
    end else begin
      cap_valid <= (state == ST_READ);
      cap_addr  <= cnt[ADDR_W-1:0];

      case (state)
        ST_IDLE: begin
          if (bus.en) begin
            state       <= ST_READ;
            cnt         <= '0;
            pass_q      <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
            checksum_q  <= '0;
          end
        end
        ST_READ: begin
          cnt <= cnt_inc;
          if (cnt_inc[CNT_W-1]) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state  <= ST_IDLE;
          pass_q <= (CHECK_IDENTITY != 0) ? (err_count_nx == '0) : 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Capture stage is never valid in IDLE, so it cannot collide with the start-time clear.
      if (cap_valid) begin
        checksum_q <= checksum_q + bus.rddata;
        if (mismatch) begin
          err_count_q <= err_count_nx;
          if (err_count_q == '0) begin
            err_addr_q <= cap_addr;
          end
        end
      end
    end
  end

  assign bus.rdy       = (state == ST_IDLE);
  assign bus.addr      = cnt[ADDR_W-1:0];
  assign bus.wren      = 1'b0;
  assign bus.pass      = pass_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_count = err_count_q;
  assign bus.checksum  = checksum_q;

endmodule

// File: tb/tb_s_readback.sv
// tb/tb_s_readback.sv - randomized self-checking bench for s_readback against a sweep model
module tb_s_readback;
  import arc4_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  s_readback_if bus ();
  s_readback_if bus_nc ();

  assign bus.en    = en;
  assign bus_nc.en = en;

  logic [7:0] mem [256];

  // Synchronous single-port RAM behaviour, one-cycle read latency.
  always @(posedge clk) begin
    bus.rddata    <= mem[bus.addr];
    bus_nc.rddata <= mem[bus_nc.addr];
  end

  s_readback #(.CHECK_IDENTITY(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  s_readback #(.CHECK_IDENTITY(0)) u_dut_nc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wren_bad = 0;
  int addr_bad = 0;

  logic       exp_pass;
  int         exp_count;
  logic [7:0] exp_eaddr;
  logic [7:0] exp_sum;

  always @(negedge clk) begin
    if (bus.wren !== 1'b0 || bus_nc.wren !== 1'b0) wren_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model();
    int s;
    s = 0;
    exp_count = 0;
    exp_eaddr = 8'h00;
    for (int i = 0; i < S_DEPTH; i++) begin
      s = s + int'(mem[i]);
      if (int'(mem[i]) != i) begin
        if (exp_count == 0) exp_eaddr = 8'(i);
        exp_count++;
      end
    end
    exp_sum  = 8'(s % 256);
    exp_pass = (exp_count == 0);
  endtask

  task automatic check_results(input string tag);
    model();
    check({tag, "_pass"},    32'(bus.pass),      32'(exp_pass));
    check({tag, "_errcnt"},  32'(bus.err_count), 32'(exp_count));
    check({tag, "_erraddr"}, 32'(bus.err_addr),  32'(exp_eaddr));
    check({tag, "_sum"},     32'(bus.checksum),  32'(exp_sum));
    check({tag, "_nc_pass"}, 32'(bus_nc.pass),   32'd1);
    check({tag, "_nc_cnt"},  32'(bus_nc.err_count), 32'd0);
    check({tag, "_nc_sum"},  32'(bus_nc.checksum),  32'(exp_sum));
    check({tag, "_nc_rdy"},  32'(bus_nc.rdy),    32'd1);
  endtask

  // Lat counts cycles after the start edge; rdy must first read high in cycle 258.
  task automatic sweep(input string tag, input bit toggle);
    int lat;
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check({tag, "_rdy_fall"}, 32'(bus.rdy), 32'd0);
    lat = 1;
    while (!bus.rdy && lat < 400) begin
      if (lat <= 256 && bus.addr != 8'(lat - 1)) addr_bad++;
      if (toggle) en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    en = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd258);
    check_results(tag);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < S_DEPTH; i++) mem[i] = 8'(i);
  endtask

  initial begin
    int highs[$];
    int nflip;

    fill_identity();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy",    32'(bus.rdy),       32'd1);
    check("rst_addr",   32'(bus.addr),      32'd0);
    check("rst_pass",   32'(bus.pass),      32'd0);
    check("rst_erraddr", 32'(bus.err_addr), 32'd0);
    check("rst_errcnt", 32'(bus.err_count), 32'd0);
    check("rst_sum",    32'(bus.checksum),  32'd0);
    @(negedge clk) rst_n = 1'b1;

    sweep("ident", 1'b0);
    check("ident_sum_const", 32'(bus.checksum), 32'h80);

    fill_identity();
    mem[37]  = 8'hFF;
    mem[200] = 8'h00;
    sweep("two_err", 1'b0);

    for (int i = 0; i < S_DEPTH; i++) mem[i] = 8'hAA;
    sweep("all_aa", 1'b0);
    check("all_aa_cnt_const", 32'(bus.err_count), 32'd255);

    for (int r = 0; r < 4; r++) begin
      fill_identity();
      if (r == 3) begin
        for (int i = 0; i < S_DEPTH; i++) mem[i] = 8'($urandom);
      end else begin
        nflip = $urandom_range(1, 6);
        for (int k = 0; k < nflip; k++) mem[$urandom_range(0, 255)] = 8'($urandom);
      end
      sweep($sformatf("rand%0d", r), r[0]);
    end

    // Back-to-back sweeps with en held high: rdy pulses once per sweep.
    fill_identity();
    mem[$urandom_range(0, 255)] = 8'($urandom);
    @(negedge clk) en = 1'b1;
    for (int c = 0; c < 3 * 258; c++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) highs.push_back(c);
    end
    en = 1'b0;
    check("hold_npulse", 32'(highs.size()), 32'd3);
    if (highs.size() == 3) begin
      check("hold_first", 32'(highs[0]), 32'd257);
      check("hold_gap1",  32'(highs[1] - highs[0]), 32'd258);
      check("hold_gap2",  32'(highs[2] - highs[1]), 32'd258);
    end
    check_results("hold");

    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rdy",     32'(bus.rdy),       32'd1);
    check("mid_addr",    32'(bus.addr),      32'd0);
    check("mid_pass",    32'(bus.pass),      32'd0);
    check("mid_erraddr", 32'(bus.err_addr),  32'd0);
    check("mid_errcnt",  32'(bus.err_count), 32'd0);
    check("mid_sum",     32'(bus.checksum),  32'd0);
    @(negedge clk) rst_n = 1'b1;
    fill_identity();
    sweep("post_rst", 1'b0);
    check("post_rst_pass_const", 32'(bus.pass), 32'd1);

    sweep("toggle", 1'b1);

    check("addr_seq", 32'(addr_bad), 32'd0);
    check("wren_zero", 32'(wren_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
